alu_result_tx_ctrl: RTL and testbench

Downstream stage of the system ALU: captures each registered ALU result (`ALU_OUT` qualified by `OUT_VALID`), splits it into bytes and sends them LSB-first to the UART transmitter over a valid/busy byte handshake. It sits between the ALU output register and the UART TX parallel input. It reports `BUSY` back to the system controller and flags results that arrive while a previous result is still being sent.

---
 rtl/alu_result_tx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_result_tx_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_tx_ctrl.sv
// alu_result_tx_ctrl
// Captures one ALU result, splits it into bytes and hands them LSB-first to
// the UART transmitter over a valid/busy byte handshake. Results that arrive
// while a transfer is in progress are dropped and flagged in OVERRUN.
// Optional feature macro: ALU_TX_CHECKSUM_EN appends an XOR checksum byte.
module alu_result_tx_ctrl #(
  parameter int OUT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [OUT_WIDTH-1:0] ALU_OUT,
  input  logic                 OUT_VALID,
  input  logic                 TX_BUSY,
  output logic [7:0]           TX_P_DATA,
  output logic                 TX_D_VALID,
  output logic                 BUSY,
  output logic                 OVERRUN,
  input  logic                 CLR_OVR
);

  localparam int BYTES  = (OUT_WIDTH + 7) / 8;
  localparam int HOLD_W = BYTES * 8;
`ifdef ALU_TX_CHECKSUM_EN
  localparam int NTX    = BYTES + 1;
`else
  localparam int NTX    = BYTES;
`endif
  localparam int IDXW   = (NTX > 1) ? $clog2(NTX) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTX - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   idx_next;
  logic [7:0]        data_next;
  logic              valid_next;
  logic              busy_next;
  logic              ovr_next;
  logic [7:0]        cur_byte;

  // Select data byte i of the zero-padded holding register.
  function automatic logic [7:0] data_byte(input logic [HOLD_W-1:0] h,
                                           input logic [IDXW-1:0]   i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      if (int'(i) == k) begin
        b = h[k*8 +: 8];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

`ifdef ALU_TX_CHECKSUM_EN
  // XOR of all data bytes, padding included.
  function automatic logic [7:0] xor_bytes(input logic [HOLD_W-1:0] h);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      c = c ^ h[k*8 +: 8];
    end
    return c;
  endfunction
`endif

  // Next-state and next-output logic for the transfer FSM and the overrun flag.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    idx_next   = idx;
    data_next  = TX_P_DATA;
    valid_next = 1'b0;
    ovr_next   = OVERRUN;
    busy_next  = 1'b0;

`ifdef ALU_TX_CHECKSUM_EN
    if (idx == LAST_IDX) begin
      cur_byte = xor_bytes(hold);
    end else begin
      cur_byte = data_byte(hold, idx);
    end
`else
    cur_byte = data_byte(hold, idx);
`endif

    case (state)
      IDLE: begin
        if (OUT_VALID) begin
          state_next                = SEND;
          hold_next                 = '0;
          hold_next[OUT_WIDTH-1:0]  = ALU_OUT;
          idx_next                  = '0;
        end else begin
          state_next = IDLE;
        end
      end
      SEND: begin
        if (!TX_BUSY) begin
          state_next = WAIT_ACK;
          data_next  = cur_byte;
          valid_next = 1'b1;
        end else begin
          state_next = SEND;
        end
      end
      WAIT_ACK: begin
        if (TX_BUSY) begin
          state_next = WAIT_DONE;
        end else begin
          state_next = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          if (idx == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            idx_next   = idx + IDXW'(1);
            state_next = SEND;
          end
        end else begin
          state_next = WAIT_DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A set on the same edge as a clear wins.
    if (OUT_VALID && (state != IDLE)) begin
      ovr_next = 1'b1;
    end else if (CLR_OVR) begin
      ovr_next = 1'b0;
    end else begin
      ovr_next = OVERRUN;
    end

    busy_next = (state_next != IDLE);
  end

  // State, datapath and output registers; async reset aborts any transfer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      hold       <= '0;
      idx        <= '0;
      TX_P_DATA  <= 8'h00;
      TX_D_VALID <= 1'b0;
      BUSY       <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      state      <= state_next;
      hold       <= hold_next;
      idx        <= idx_next;
      TX_P_DATA  <= data_next;
      TX_D_VALID <= valid_next;
      BUSY       <= busy_next;
      OVERRUN    <= ovr_next;
    end
  end

endmodule

// File: tb/tb_alu_result_tx_ctrl.sv
// Testbench for alu_result_tx_ctrl: directed scenarios plus randomized
// traffic, checked against a transaction-level reference model.
module tb_alu_result_tx_ctrl;

  localparam int W        = 12;
  localparam int BYTES_TB = (W + 7) / 8;
`ifdef ALU_TX_CHECKSUM_EN
  localparam int NTX_TB   = BYTES_TB + 1;
`else
  localparam int NTX_TB   = BYTES_TB;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] ALU_OUT = '0;
  logic         OUT_VALID = 1'b0;
  logic         TX_BUSY = 1'b0;
  logic [7:0]   TX_P_DATA;
  logic         TX_D_VALID;
  logic         BUSY;
  logic         OVERRUN;
  logic         CLR_OVR = 1'b0;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] m_q[$];
  bit         m_busy = 1'b0;
  bit         m_ovr  = 1'b0;
  int         m_rises = 0;
  bit         prev_txb = 1'b0;

  // UART model controls
  bit uart_force = 1'b0;
  int uart_hold  = 10;
  int ucnt       = 0;
  int pulse_cnt  = 0;
  bit prev_valid = 1'b0;

  alu_result_tx_ctrl #(.OUT_WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .TX_BUSY   (TX_BUSY),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VALID(TX_D_VALID),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN),
    .CLR_OVR   (CLR_OVR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model: busy one cycle after a valid pulse, for uart_hold cycles.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (uart_force) begin
        TX_BUSY = 1'b1;
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) TX_BUSY = 1'b0;
      end else if (TX_D_VALID) begin
        TX_BUSY = 1'b1;
        ucnt    = uart_hold;
      end else begin
        TX_BUSY = 1'b0;
      end
    end
  end

  // Reference model: a result is taken only when no transfer is outstanding;
  // a transfer ends at the first edge with TX_BUSY low after the UART has
  // acknowledged every byte of it.
  initial begin
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        m_busy  = 1'b0;
        m_ovr   = 1'b0;
        m_rises = 0;
        m_q.delete();
        prev_txb = TX_BUSY;
      end else begin
        bit old_busy;
        old_busy = m_busy;
        if (old_busy) begin
          if (TX_BUSY && !prev_txb) m_rises++;
          if (m_rises == NTX_TB && !TX_BUSY) m_busy = 1'b0;
        end else if (OUT_VALID) begin
          int unsigned v;
          logic [7:0] b, cs;
          v  = 32'(ALU_OUT);
          cs = 8'h00;
          m_busy  = 1'b1;
          m_rises = 0;
          for (int i = 0; i < BYTES_TB; i++) begin
            b  = 8'((v >> (8 * i)) & 32'hFF);
            cs = cs ^ b;
            m_q.push_back(b);
          end
`ifdef ALU_TX_CHECKSUM_EN
          m_q.push_back(cs);
`endif
        end
        if (OUT_VALID && old_busy) m_ovr = 1'b1;
        else if (CLR_OVR) m_ovr = 1'b0;
        prev_txb = TX_BUSY;
      end
    end
  end

  // Monitor: compare outputs with the model away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("busy", BUSY, m_busy);
        chk("overrun", OVERRUN, m_ovr);
        if (TX_D_VALID) begin
          pulse_cnt++;
          chk("pulse_width", prev_valid, 1'b0);
          if (m_q.size() == 0) begin
            chk("unexpected_pulse", TX_D_VALID, 1'b0);
          end else begin
            chk("tx_byte", TX_P_DATA, m_q.pop_front());
          end
        end
      end
      prev_valid = TX_D_VALID;
    end
  end

  task automatic send(input logic [W-1:0] v);
    @(negedge CLK);
    ALU_OUT   = v;
    OUT_VALID = 1'b1;
    @(negedge CLK);
    OUT_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_timeout", BUSY, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    // reset values
    #12;
    chk("rst_data", TX_P_DATA, 8'h00);
    chk("rst_valid", TX_D_VALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_ovr", OVERRUN, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    idle_cycles(3);

    // latency and multi-byte padding: 12'hABC -> BC, 0A
    uart_hold = 10;
    @(negedge CLK);
    ALU_OUT   = 12'hABC;
    OUT_VALID = 1'b1;
    @(negedge CLK);
    OUT_VALID = 1'b0;
    chk("lat_valid_early", TX_D_VALID, 1'b0);
    chk("lat_busy", BUSY, 1'b1);
    @(negedge CLK);
    chk("lat_valid", TX_D_VALID, 1'b1);
    chk("first_byte", TX_P_DATA, 8'hBC);
    wait_idle(200);
    chk("hold_last", TX_P_DATA, 8'h0A);

    // TX stalled before and during capture
    uart_force = 1'b1;
    idle_cycles(20);
    p0 = pulse_cnt;
    send(12'h5A5);
    idle_cycles(10);
    chk("stall_no_pulse", pulse_cnt, p0);
    uart_force = 1'b0;
    wait_idle(300);
    chk("stall_pulses", pulse_cnt, p0 + NTX_TB);

    // overrun, clear, and set-beats-clear
    p0 = pulse_cnt;
    send(12'h011);
    idle_cycles(3);
    send(12'h033);
    wait_idle(300);
    chk("ovr_set", OVERRUN, 1'b1);
    chk("ovr_pulses", pulse_cnt, p0 + NTX_TB);
    @(negedge CLK);
    CLR_OVR = 1'b1;
    @(negedge CLK);
    CLR_OVR = 1'b0;
    chk("ovr_clear", OVERRUN, 1'b0);
    send(12'h0F0);
    idle_cycles(2);
    @(negedge CLK);
    ALU_OUT   = 12'h0EE;
    OUT_VALID = 1'b1;
    CLR_OVR   = 1'b1;
    @(negedge CLK);
    OUT_VALID = 1'b0;
    CLR_OVR   = 1'b0;
    chk("ovr_same_edge", OVERRUN, 1'b1);
    wait_idle(300);

    // reset in WAIT_DONE of byte 0
    p0 = pulse_cnt;
    send(12'h7C3);
    for (int i = 0; i < 50 && !TX_BUSY; i++) @(negedge CLK);
    chk("rst_wait_ack", TX_BUSY, 1'b1);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_data", TX_P_DATA, 8'h00);
    chk("mid_rst_valid", TX_D_VALID, 1'b0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_ovr", OVERRUN, 1'b0);
    idle_cycles(2);
    #2;
    RST = 1'b1;
    idle_cycles(40);
    chk("mid_rst_pulses", pulse_cnt, p0 + 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      uart_hold = $urandom_range(1, 6);
      ALU_OUT   = W'($urandom);
      OUT_VALID = ($urandom_range(0, 11) == 0);
      CLR_OVR   = ($urandom_range(0, 29) == 0);
    end
    @(negedge CLK);
    OUT_VALID = 1'b0;
    CLR_OVR   = 1'b0;
    wait_idle(300);
    idle_cycles(2);
    chk("queue_drained", m_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
